// File: rtl/corescore_arb_pkg.sv
// Shared types and constants for the corescore stream arbiter.
// State encoding, header magic nibble and the supported source-count ceiling.
package corescore_arb_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StHdr  = 2'd1,
      StPass = 2'd2
   } arb_state_e;

   localparam logic [3:0]  HDR_MAGIC   = 4'hA;
   localparam int unsigned MAX_NUM_SRC = 16;

endpackage

// File: rtl/corescore_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module corescore_rr_pick #(
   parameter int unsigned NUM_SRC = 4,
   localparam int unsigned SRC_W  = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [SRC_W-1:0]   ptr,
   output logic [SRC_W-1:0]   idx,
   output logic               any
);

   int unsigned cand;

   // Scan from farthest to nearest so the nearest hit from ptr wins.
   always_comb begin
      idx  = '0;
      any  = 1'b0;
      cand = 0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         cand = int'(ptr) + i;
         if (cand >= NUM_SRC) begin
            cand = cand - NUM_SRC;
         end
         if (req[cand]) begin
            idx = SRC_W'(cand);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/corescore_stream_arbiter.sv
// Packet-atomic round-robin arbiter sharing one byte-stream sink among NUM_SRC sources.
// Define CORESCORE_ARB_HDR_EN to prefix each packet with a {4'hA, source id} header beat.
module corescore_stream_arbiter
   import corescore_arb_pkg::*;
#(
   parameter int unsigned NUM_SRC = 4,
   localparam int unsigned SRC_W  = $clog2(NUM_SRC)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [8*NUM_SRC-1:0] i_tdata,
   input  logic [NUM_SRC-1:0]   i_tlast,
   input  logic [NUM_SRC-1:0]   i_tvalid,
   output logic [NUM_SRC-1:0]   o_tready,
   output logic [7:0]           o_tdata,
   output logic                 o_tlast,
   output logic                 o_tvalid,
   input  logic                 i_tready,
   output logic [SRC_W-1:0]     o_grant,
   output logic                 o_busy
);

   arb_state_e         state_q, state_d;
   logic [SRC_W-1:0]   grant_q, grant_d;
   logic [SRC_W-1:0]   ptr_q, ptr_d;
   logic [SRC_W-1:0]   pick_idx;
   logic               pick_any;
   logic [7:0]         sel_data;
   logic               sel_last;
   logic               sel_valid;
   logic [NUM_SRC-1:0] grant_oh;

   corescore_rr_pick #(
      .NUM_SRC (NUM_SRC)
   ) u_pick (
      .req (i_tvalid),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      sel_data  = '0;
      sel_last  = 1'b0;
      sel_valid = 1'b0;
      grant_oh  = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (grant_q == SRC_W'(k)) begin
            sel_data    = i_tdata[8*k +: 8];
            sel_last    = i_tlast[k];
            sel_valid   = i_tvalid[k];
            grant_oh[k] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      ptr_d    = ptr_q;
      o_tvalid = 1'b0;
      o_tdata  = '0;
      o_tlast  = 1'b0;
      o_tready = '0;
      case (state_q)
         StIdle: begin
            if (pick_any) begin
               grant_d = pick_idx;
`ifdef CORESCORE_ARB_HDR_EN
               state_d = StHdr;
`else
               state_d = StPass;
`endif
            end
         end
`ifdef CORESCORE_ARB_HDR_EN
         StHdr: begin
            o_tvalid = 1'b1;
            o_tdata  = {HDR_MAGIC, 4'(grant_q)};
            if (i_tready) begin
               state_d = StPass;
            end
         end
`endif
         StPass: begin
            o_tvalid = sel_valid;
            o_tdata  = sel_data;
            o_tlast  = sel_last;
            o_tready = i_tready ? grant_oh : '0;
            if (sel_valid && i_tready && sel_last) begin
               state_d = StIdle;
               // Just-served source drops to lowest priority.
               ptr_d   = (grant_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_q + SRC_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   assign o_grant = grant_q;
   assign o_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_corescore_stream_arbiter.sv
// Directed self-checking bench for corescore_stream_arbiter (NUM_SRC=4).
// Inputs change and outputs are sampled in the low half of the clock, away from posedge.
module tb_corescore_stream_arbiter;

   logic        clk;
   logic        rst_n;
   logic [31:0] tdata;
   logic [3:0]  tlast;
   logic [3:0]  tvalid;
   logic [3:0]  tready_o;
   logic [7:0]  odata;
   logic        olast;
   logic        ovalid;
   logic        sink_ready;
   logic [1:0]  grant;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef CORESCORE_ARB_HDR_EN
   localparam int Per = 3;
`else
   localparam int Per = 2;
`endif

   corescore_stream_arbiter #(
      .NUM_SRC (4)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_tdata  (tdata),
      .i_tlast  (tlast),
      .i_tvalid (tvalid),
      .o_tready (tready_o),
      .o_tdata  (odata),
      .o_tlast  (olast),
      .o_tvalid (ovalid),
      .i_tready (sink_ready),
      .o_grant  (grant),
      .o_busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic skip_hdr(input int src);
`ifdef CORESCORE_ARB_HDR_EN
      sink_ready = 1'b1;
      #1;
      check_eq("hdr_data", odata, {4'hA, 4'(src)});
      check_eq("hdr_valid", ovalid, 1);
      check_eq("hdr_last", olast, 0);
      check_eq("hdr_tready", tready_o, 0);
      @(negedge clk);
`else
      if (src < 0) $display("bad source index");
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      tvalid = '0;
      tlast = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Send one packet of n bytes from src; rdy gives the sink-ready bit per PASS cycle.
   task automatic xfer(input int src, input int n, input logic [63:0] bytes,
                       input logic [7:0] rdy);
      int i;
      int cyc;
      logic [7:0] b;
      @(negedge clk);
      sink_ready = 1'b1;
      tvalid[src] = 1'b1;
      tdata[8*src +: 8] = bytes[7:0];
      tlast[src] = (n == 1);
      #1;
      check_eq("idle_valid", ovalid, 0);
      check_eq("idle_busy", busy, 0);
      @(negedge clk);
      #1;
      check_eq("grant", grant, src);
      check_eq("busy", busy, 1);
      skip_hdr(src);
      i = 0;
      cyc = 0;
      while (i < n && cyc < 64) begin
         b = bytes[8*i +: 8];
         tdata[8*src +: 8] = b;
         tlast[src] = (i == n - 1);
         sink_ready = rdy[cyc % 8];
         #1;
         check_eq("pass_data", odata, b);
         check_eq("pass_last", olast, (i == n - 1));
         check_eq("pass_valid", ovalid, 1);
         check_eq("pass_tready", tready_o, rdy[cyc % 8] ? (32'd1 << src) : 32'd0);
         if (rdy[cyc % 8]) i++;
         cyc++;
         @(negedge clk);
      end
      check_eq("pkt_done", i, n);
      tvalid[src] = 1'b0;
      tlast[src] = 1'b0;
      sink_ready = 1'b1;
      #1;
      check_eq("post_busy", busy, 0);
      check_eq("post_valid", ovalid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      tvalid = 4'hF;
      tlast = '0;
      tdata = '0;
      sink_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_valid", ovalid, 0);
      check_eq("rst_tready", tready_o, 0);
      check_eq("rst_grant", grant, 0);
      check_eq("rst_busy", busy, 0);
      tvalid = '0;
      rst_n = 1'b1;

      // Single source, src2 sends 11,22,33.
      xfer(2, 3, 64'h0000_0000_0033_2211, 8'hFF);
      // Backpressure on src1: ready toggles 1/0.
      xfer(1, 4, 64'h0000_0000_D4C3_B2A1, 8'b0101_0101);

      // Round robin: all sources hold single-beat packets.
      do_reset();
      @(negedge clk);
      tvalid = 4'hF;
      tlast = 4'hF;
      tdata = 32'h1312_1110;
      sink_ready = 1'b1;
      for (int c = 0; c < Per * 5; c++) begin
         #1;
         check_eq("rr_busy", busy, (c % Per) != 0);
         if (c % Per == Per - 1) begin
            check_eq("rr_grant", grant, (c / Per) % 4);
            check_eq("rr_data", odata, 8'h10 + 8'((c / Per) % 4));
            check_eq("rr_last", olast, 1);
         end else begin
            check_eq("rr_gap_tready", tready_o, 0);
         end
         @(negedge clk);
      end
      tvalid = '0;
      tlast = '0;

      // Mid-packet stall by src0 while src3 requests, then reset inside src3's packet.
      do_reset();
      @(negedge clk);
      tvalid = 4'b1001;
      tdata = 32'h3100_00AA;
      tlast = 4'b0000;
      sink_ready = 1'b1;
      #1;
      check_eq("st_idle", busy, 0);
      @(negedge clk);
      #1;
      check_eq("st_grant0", grant, 0);
      skip_hdr(0);
      #1;
      check_eq("st_b0", odata, 8'hAA);
      @(negedge clk);
      tvalid[0] = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         check_eq("st_hold_grant", grant, 0);
         check_eq("st_hold_valid", ovalid, 0);
         check_eq("st_hold_busy", busy, 1);
         check_eq("st_hold_tready", tready_o, 4'b0001);
         @(negedge clk);
      end
      tvalid[0] = 1'b1;
      tdata[7:0] = 8'hBB;
      tlast[0] = 1'b1;
      #1;
      check_eq("st_b1", odata, 8'hBB);
      check_eq("st_b1_last", olast, 1);
      @(negedge clk);
      tvalid[0] = 1'b0;
      tlast[0] = 1'b0;
      #1;
      check_eq("st_bubble", busy, 0);
      @(negedge clk);
      #1;
      check_eq("st_grant3", grant, 3);
      skip_hdr(3);
      #1;
      check_eq("rm_b0", odata, 8'h31);
      @(negedge clk);
      tdata[31:24] = 8'h32;
      #1;
      check_eq("rm_b1", odata, 8'h32);
      @(negedge clk);
      tdata[31:24] = 8'h33;
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      check_eq("rm_valid", ovalid, 0);
      check_eq("rm_busy", busy, 0);
      check_eq("rm_grant", grant, 0);
      check_eq("rm_tready", tready_o, 0);
      rst_n = 1'b1;
      tvalid = '0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
